// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer and its return-address stack.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam int unsigned PC_INC           = 4;

  typedef struct packed {
    logic push;
    logic pop;
  } ras_cmd_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with a saturating entry count; the oldest entry
// is overwritten when a push arrives while full.
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int N_BITS    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  ras_cmd_t          cmd_i,
  input  logic [N_BITS-1:0] push_data_i,
  output logic [N_BITS-1:0] top_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]                  ptr_q, ptr_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [RAS_DEPTH-1:0][N_BITS-1:0]  mem_q, mem_d;
  logic                              empty, full;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(RAS_DEPTH));

  // ptr_q always addresses the current top entry.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (cmd_i.push && cmd_i.pop && !empty) begin
      mem_d[ptr_q] = push_data_i;
    end else if (cmd_i.push) begin
      ptr_d        = ptr_q + PTR_W'(1);
      mem_d[ptr_d] = push_data_i;
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (cmd_i.pop && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is meaningless while count is zero, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top_o   = empty ? '0 : mem_q[ptr_q];
  assign empty_o = empty;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot/run/trap FSM, exception and eret handling, redirects,
// and call/return prediction through a small return-address stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                N_BITS       = 32,
  parameter logic [N_BITS-1:0] RESET_VECTOR = N_BITS'(DEF_RESET_VECTOR),
  parameter logic [N_BITS-1:0] EXC_VECTOR   = N_BITS'(DEF_EXC_VECTOR),
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [N_BITS-1:0] redirect_pc_i,
  input  logic              exc_i,
  input  logic              eret_i,
  input  logic              ras_push_i,
  input  logic              ras_pop_i,
  output logic [N_BITS-1:0] pc_o,
  output logic              pc_valid_o,
  output logic [N_BITS-1:0] epc_o,
  output logic              badaddr_o,
  output logic [N_BITS-1:0] ras_top_o,
  output logic              ras_empty_o
);

  pc_state_e         state_q, state_d;
  logic [N_BITS-1:0] pc_q, pc_d;
  logic [N_BITS-1:0] epc_q, epc_d;
  logic              badaddr_q, badaddr_d;
  logic [N_BITS-1:0] pc_inc;
  logic              misalign, take_exc;
  ras_cmd_t          ras_cmd;

  assign misalign = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign take_exc = exc_i || misalign;
  assign pc_inc   = pc_q + N_BITS'(PC_INC);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    badaddr_d = badaddr_q;
    ras_cmd   = '0;
    unique case (state_q)
      ST_BOOT, ST_TRAP: state_d = ST_RUN;
      ST_RUN: begin
        if (take_exc) begin
          pc_d      = EXC_VECTOR;
          epc_d     = pc_q;
          badaddr_d = misalign;
          state_d   = ST_TRAP;
        end else begin
          if (eret_i)                pc_d = epc_q;
          else if (redirect_valid_i) pc_d = redirect_pc_i;
          else if (!stall_i)         pc_d = pc_inc;
          // Call/return hints only count on a cycle that actually advances.
          if (!stall_i) begin
            ras_cmd.push = ras_push_i;
            ras_cmd.pop  = ras_pop_i;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      badaddr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      badaddr_q <= badaddr_d;
    end
  end

  pc_ras #(
    .N_BITS    (N_BITS),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .cmd_i       (ras_cmd),
    .push_data_i (pc_inc),
    .top_o       (ras_top_o),
    .empty_o     (ras_empty_o)
  );

  assign pc_o       = pc_q;
  assign pc_valid_o = (state_q == ST_RUN);
  assign epc_o      = epc_q;
  assign badaddr_o  = badaddr_q;

endmodule
